// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide over XLEN cycles.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies with a zero operand finish in one cycle.
module muldiv_seq_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic [1:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_mul_op, is_div_op, accept;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, mul_add, rem_sh, div_diff;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo, rem, mul_res, div_res;

    always_comb begin
        is_mul_op = (alu_op == 4'd13 || alu_op == 4'd14 || alu_op == 4'd3) && !funct3[2];
        is_div_op = (alu_op == 4'd15 || alu_op == 4'd4) && funct3[2];
        accept    = start && !flush && (is_mul_op || is_div_op);

        if (is_div_op) begin
            a_signed = !funct3[0];
            b_signed = !funct3[0];
        end else begin
            a_signed = (funct3[1:0] != 2'd3);
            b_signed = !funct3[1];
        end
        a_neg = a_signed && src_a[XLEN-1];
        b_neg = b_signed && src_b[XLEN-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;

        // Multiply: hi accumulates, lo holds the multiplier and shifts out as product bits shift in.
        mul_sum = {1'b0, hi_q} + {1'b0, opnd_q};
        mul_add = lo_q[0] ? mul_sum : {1'b0, hi_q};

        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, opnd_q};

        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_add[XLEN:1];
            step_lo = {mul_add[0], lo_q[XLEN-1:1]};
        end

        prod    = {step_hi, step_lo};
        prod_s  = neg_q ? -prod : prod;
        mul_res = (f3_q == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quo     = neg_q ? -step_lo : step_lo;
        rem     = rneg_q ? -step_hi : step_hi;
        div_res = f3_q[1] ? rem : quo;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    hi_d     = '0;
                    is_div_d = is_div_op;
                    f3_d     = funct3[1:0];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    lo_d     = is_div_op ? a_mag : b_mag;
                    opnd_d   = is_div_op ? b_mag : a_mag;
                    if (is_div_op && src_b == '0) begin
                        state_d  = S_FIN;
                        result_d = funct3[1] ? src_a : '1;
                    end else if (is_div_op && !funct3[0] &&
                                 src_a == {1'b1, {(XLEN-1){1'b0}}} && src_b == '1) begin
                        state_d  = S_FIN;
                        result_d = funct3[1] ? '0 : src_a;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!is_div_op && (src_a == '0 || src_b == '0)) begin
                        state_d  = S_FIN;
                        result_d = '0;
                    end
`endif
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d  = S_FIN;
                        result_d = is_div_q ? div_res : mul_res;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_FIN);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit (XLEN=32); honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam int FULL_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    muldiv_seq_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_op (alu_op),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle, scrambles operands afterwards, and waits (bounded) for done.
    // lat = cycles from accept edge to the cycle where done is seen; -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt, output logic bsy_at_done);
        @(negedge clk);
        alu_op = op; funct3 = f3; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; src_a = ~a; src_b = ~b;
        lat = 1; bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        bsy_at_done = busy;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mul;
        vec_t v[4];
        int lat, bcnt;
        logic bd;
        v[0] = '{4'd13, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, FULL_LAT};
        v[1] = '{4'd3,  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT};
        v[2] = '{4'd13, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FULL_LAT};
        v[3] = '{4'd14, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, FULL_LAT};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].op, v[i].f3, v[i].a, v[i].b, lat, bcnt, bd);
            checks++; if (result !== v[i].exp) begin errors++; $display("FAIL mul[%0d]_result: got %h expected %h", i, result, v[i].exp); end
            checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL mul[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
            checks++; if (bcnt !== v[i].lat - 1) begin errors++; $display("FAIL mul[%0d]_busy_cycles: got %0d expected %0d", i, bcnt, v[i].lat - 1); end
            checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mul[%0d]_busy_at_done: got %b expected 0", i, bd); end
        end
    endtask

    task automatic test_div;
        vec_t v[9];
        int lat, bcnt;
        logic bd;
        v[0] = '{4'd15, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, FULL_LAT};
        v[1] = '{4'd15, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, FULL_LAT};
        v[2] = '{4'd4,  3'd5, 32'd100,      32'd7,        32'd14,       FULL_LAT};
        v[3] = '{4'd4,  3'd7, 32'd100,      32'd7,        32'd2,        FULL_LAT};
        v[4] = '{4'd15, 3'd4, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, FULL_LAT};
        v[5] = '{4'd4,  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        v[6] = '{4'd4,  3'd7, 32'd5,        32'd0,        32'd5,        1};
        v[7] = '{4'd15, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[8] = '{4'd15, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].op, v[i].f3, v[i].a, v[i].b, lat, bcnt, bd);
            checks++; if (result !== v[i].exp) begin errors++; $display("FAIL div[%0d]_result: got %h expected %h", i, result, v[i].exp); end
            checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL div[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
            checks++; if (bcnt !== v[i].lat - 1) begin errors++; $display("FAIL div[%0d]_busy_cycles: got %0d expected %0d", i, bcnt, v[i].lat - 1); end
            checks++; if (bd !== 1'b0) begin errors++; $display("FAIL div[%0d]_busy_at_done: got %b expected 0", i, bd); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        logic bd;
        run_op(4'd4, 3'd5, 32'd100, 32'd7, lat, bcnt, bd);
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL b2b_first_result: got %h expected 0000000e", result); end
        run_op(4'd13, 3'd0, 32'd7, 32'hFFFFFFFD, lat, bcnt, bd);
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++; if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL b2b_second_result: got %h expected ffffffeb", result); end
    endtask

    task automatic test_flush;
        logic [31:0] prev;
        int lat, bcnt, seen;
        logic bd;
        prev = result;
        @(negedge clk);
        alu_op = 4'd13; funct3 = 3'd0; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", done); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_result: got %h expected %h", result, prev); end
        run_op(4'd13, 3'd0, 32'd3, 32'd5, lat, bcnt, bd);
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL flush_restart_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_restart_result: got %h expected 0000000f", result); end
        // start together with flush in IDLE must not be accepted
        @(negedge clk);
        alu_op = 4'd15; funct3 = 3'd4; src_a = 32'd9; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (36) begin
            if (busy || done) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_start_idle: got %0d active cycles expected 0", seen); end
        checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_start_idle_result: got %h expected 0000000f", result); end
    endtask

    task automatic test_ignore;
        logic [3:0] ops[3];
        logic [2:0] f3s[3];
        int seen;
        ops[0] = 4'd5;  f3s[0] = 3'd0;
        ops[1] = 4'd15; f3s[1] = 3'd1;
        ops[2] = 4'd13; f3s[2] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alu_op = ops[i]; funct3 = f3s[i]; src_a = 32'd6; src_b = 32'd3; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            seen = 0;
            repeat (36) begin
                if (busy || done) seen++;
                @(negedge clk);
            end
            checks++; if (seen !== 0) begin errors++; $display("FAIL ignore[%0d]: got %0d active cycles expected 0", i, seen); end
        end
    endtask

    task automatic test_early_out;
        int lat, bcnt;
        logic bd;
        run_op(4'd13, 3'd0, 32'd0, 32'd9, lat, bcnt, bd);
        checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL early_out_latency: got %0d expected %0d", lat, ZERO_LAT); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL early_out_result: got %h expected 00000000", result); end
        run_op(4'd3, 3'd3, 32'd12, 32'd11, lat, bcnt, bd);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL mulhu_small_result: got %h expected 00000000", result); end
        run_op(4'd13, 3'd0, 32'd12, 32'd11, lat, bcnt, bd);
        checks++; if (result !== 32'd132) begin errors++; $display("FAIL mul_small_result: got %h expected 00000084", result); end
    endtask

    task automatic test_async_reset;
        int seen;
        @(negedge clk);
        alu_op = 4'd13; funct3 = 3'd0; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL areset_result: got %h expected 00000000", result); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL areset_no_restart: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_ignore();
        test_early_out();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
